// File: rtl/softmax_out_pack_if.sv
// AXI-Stream style handshake bundle for the softmax packer; WIDTH sets the data width.
`default_nettype none

interface softmax_out_pack_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             last;
  logic             ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

`default_nettype wire

// File: rtl/softmax_out_pack.sv
// ==========================================================================
// softmax_out_pack: packs pairs of softmax elements into 2*data_size words.
// Optional macro PACK_FRAME_CNT_EN adds elem_cnt_o / frame_done_o.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module softmax_out_pack #(
  parameter int data_size = 16
) (
  input  logic                axi_clock_i,
  input  logic                axi_reset_n_i,
  softmax_out_pack_if.slave   s_axis,
  softmax_out_pack_if.master  m_axis
`ifdef PACK_FRAME_CNT_EN
  ,
  output logic [15:0]         elem_cnt_o,
  output logic                frame_done_o
`endif
);

  typedef enum logic [1:0] {
    S_LO  = 2'd0,
    S_HI  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  localparam logic [data_size-1:0] c_zero = '0;

  state_t                   r_state;
  logic [data_size-1:0]     r_lo;
  logic [2*data_size-1:0]   r_data;
  logic                     r_last;
  logic                     r_valid;

  logic w_s_ready;
  logic w_s_fire;
  logic w_m_fire;

  // A held word may be replaced in the same cycle it is consumed downstream.
  assign w_s_ready = (r_state != S_OUT) | m_axis.ready;
  assign w_s_fire  = s_axis.valid & w_s_ready;
  assign w_m_fire  = r_valid & m_axis.ready;

  assign s_axis.ready = w_s_ready;
  assign m_axis.valid = r_valid;
  assign m_axis.data  = r_data;
  assign m_axis.last  = r_last;

  always_ff @(posedge axi_clock_i) begin
    if (!axi_reset_n_i) begin
      r_state <= S_LO;
      r_lo    <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LO: begin
          if (w_s_fire) begin
            r_lo <= s_axis.data;
            if (s_axis.last) begin
              r_data  <= {c_zero, s_axis.data};
              r_last  <= 1'b1;
              r_valid <= 1'b1;
              r_state <= S_OUT;
            end else begin
              r_state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (w_s_fire) begin
            r_data  <= {s_axis.data, r_lo};
            r_last  <= s_axis.last;
            r_valid <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (w_m_fire) begin
            if (w_s_fire) begin
              r_lo <= s_axis.data;
              if (s_axis.last) begin
                r_data <= {c_zero, s_axis.data};
                r_last <= 1'b1;
              end else begin
                r_valid <= 1'b0;
                r_state <= S_HI;
              end
            end else begin
              r_valid <= 1'b0;
              r_state <= S_LO;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_LO;
        end
      endcase
    end
  end

`ifdef PACK_FRAME_CNT_EN
  logic [15:0] r_run;
  logic [15:0] r_pend;
  logic [15:0] r_cnt;
  logic        r_done;

  // r_pend holds the length of the frame whose last word is still in flight.
  always_ff @(posedge axi_clock_i) begin
    if (!axi_reset_n_i) begin
      r_run  <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_m_fire & r_last;
      if (w_m_fire & r_last) begin
        r_cnt <= r_pend;
      end
      if (w_s_fire) begin
        if (s_axis.last) begin
          r_pend <= r_run + 16'd1;
          r_run  <= '0;
        end else begin
          r_run  <= r_run + 16'd1;
        end
      end
    end
  end

  assign elem_cnt_o   = r_cnt;
  assign frame_done_o = r_done;
`endif

endmodule

`default_nettype wire
